// File: rtl/e203_exu_fpu_fmis_cvtws_wbck_pkg.sv
// Shared FPU constants for the fcvt.w[u].s result finalisation path:
// fflags layout, integer saturation values and exponent thresholds.
package e203_exu_fpu_fmis_cvtws_wbck_pkg;

    localparam int XLEN     = 32;
    localparam int FFLAGS_W = 5;
    localparam int RD_W     = 5;

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    localparam logic [31:0] INT32_MAX     = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN     = 32'h8000_0000;
    localparam logic [31:0] UINT32_MAX    = 32'hFFFF_FFFF;
    localparam logic [31:0] RS1_INT32_MIN = 32'hCF00_0000;

    localparam logic [7:0] EXP_ONE   = 8'd127;
    localparam logic [7:0] EXP_EXACT = 8'd150;
    localparam logic [7:0] EXP_SAT_S = 8'd158;
    localparam logic [7:0] EXP_SAT_U = 8'd159;

    typedef struct packed {
        logic [XLEN-1:0]     wdat;
        logic [RD_W-1:0]     rd;
        logic [FFLAGS_W-1:0] fflags;
    } wbck_ent_t;

    function automatic logic [FFLAGS_W-1:0] pack_fflags(input logic nv, input logic nx);
        logic [FFLAGS_W-1:0] f;
        f           = '0;
        f[FFLAG_NV] = nv;
        f[FFLAG_NX] = nx;
        return f;
    endfunction

endpackage

// File: rtl/e203_exu_fpu_fmis_cvt_fix.sv
// Combinational special-case correction and fflags generation for a
// float-to-int32 converter result (signed and unsigned variants).
module e203_exu_fpu_fmis_cvt_fix
    import e203_exu_fpu_fmis_cvtws_wbck_pkg::*;
(
    input  logic [31:0] rs1,
    input  logic [31:0] raw_wdat,
    input  logic        unsgn,
    output logic [31:0] fix_wdat,
    output logic [4:0]  fix_fflags
);

    // Any fraction bits below the binary point make the truncated result inexact.
    function automatic logic calc_inexact(input logic [7:0] e, input logic [22:0] m);
        logic [4:0]  k;
        logic [22:0] mask;
        logic        nx;
        k    = 5'(EXP_EXACT - e);
        mask = 23'((24'h1 << k) - 24'h1);
        if (e >= EXP_EXACT)
            nx = 1'b0;
        else if (e < EXP_ONE)
            nx = (e != 8'd0) || (m != 23'd0);
        else
            nx = |(m & mask);
        return nx;
    endfunction

    // Values in [2^31, 2^32) are exact integers; the converter clips them.
    function automatic logic [31:0] sat_u_top(input logic [22:0] m);
        return {1'b1, m, 8'h00};
    endfunction

    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic        is_nan;
    logic        is_zero;
    logic        nv;
    logic        nx;

    assign s       = rs1[31];
    assign e       = rs1[30:23];
    assign m       = rs1[22:0];
    assign is_nan  = (e == 8'hFF) && (m != 23'd0);
    assign is_zero = (e == 8'd0) && (m == 23'd0);

    always_comb begin
        fix_wdat = raw_wdat;
        nv       = 1'b0;
        nx       = 1'b0;
        if (!unsgn) begin
            if (is_nan || (!s && e >= EXP_SAT_S)) begin
                fix_wdat = INT32_MAX;
                nv       = 1'b1;
            end else if (rs1 == RS1_INT32_MIN) begin
                fix_wdat = INT32_MIN;
            end else if (s && e >= EXP_SAT_S) begin
                fix_wdat = INT32_MIN;
                nv       = 1'b1;
            end else begin
                nx = calc_inexact(e, m);
            end
        end else begin
            if (is_nan || (!s && e >= EXP_SAT_U)) begin
                fix_wdat = UINT32_MAX;
                nv       = 1'b1;
            end else if (!s && e == EXP_SAT_S) begin
                fix_wdat = sat_u_top(m);
            end else if (s && e >= EXP_ONE) begin
                fix_wdat = 32'd0;
                nv       = 1'b1;
            end else if (is_zero) begin
                fix_wdat = 32'd0;
            end else if (s) begin
                fix_wdat = 32'd0;
                nx       = 1'b1;
            end else begin
                nx = calc_inexact(e, m);
            end
        end
    end

    assign fix_fflags = pack_fflags(nv, nx);

endmodule

// File: rtl/e203_exu_fpu_fmis_cvtws_wbck.sv
// fcvt.w[u].s writeback stage: corrects the converter result, registers it
// in a 2-entry skid buffer and accumulates sticky fflags.
module e203_exu_fpu_fmis_cvtws_wbck
    import e203_exu_fpu_fmis_cvtws_wbck_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_wdat,
    input  logic [31:0] i_rs1,
    input  logic        i_unsgn,
    input  logic [4:0]  i_rd,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [31:0] o_wdat,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_fflags,
    output logic [4:0]  fflags_acc,
    input  logic        fflags_clr
);

    logic [31:0] fix_wdat_p0;
    logic [4:0]  fix_fflags_p0;
    wbck_ent_t   in_ent_p0;
    logic        acc_p0;

    wbck_ent_t   head_p1;
    wbck_ent_t   tail_p1;
    logic        vld_p1;
    logic        tail_vld_p1;
    logic        deq_p1;

    e203_exu_fpu_fmis_cvt_fix u_cvt_fix (
        .rs1        (i_rs1),
        .raw_wdat   (i_wdat),
        .unsgn      (i_unsgn),
        .fix_wdat   (fix_wdat_p0),
        .fix_fflags (fix_fflags_p0)
    );

    assign in_ent_p0 = '{wdat: fix_wdat_p0, rd: i_rd, fflags: fix_fflags_p0};
    assign acc_p0    = i_valid && i_ready;
    assign deq_p1    = vld_p1 && o_ready;

    // p0 -> p1: head is the output register, tail only fills under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            tail_vld_p1 <= 1'b0;
            head_p1     <= '0;
            tail_p1     <= '0;
        end else if (deq_p1) begin
            if (tail_vld_p1) begin
                head_p1     <= tail_p1;
                tail_vld_p1 <= 1'b0;
            end else if (acc_p0) begin
                head_p1 <= in_ent_p0;
            end else begin
                vld_p1 <= 1'b0;
            end
        end else if (acc_p0) begin
            if (!vld_p1) begin
                head_p1 <= in_ent_p0;
                vld_p1  <= 1'b1;
            end else begin
                tail_p1     <= in_ent_p0;
                tail_vld_p1 <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fflags_acc <= '0;
        else if (deq_p1)
            fflags_acc <= (fflags_clr ? 5'd0 : fflags_acc) | head_p1.fflags;
        else if (fflags_clr)
            fflags_acc <= '0;
    end

    assign i_ready  = !tail_vld_p1;
    assign o_valid  = vld_p1;
    assign o_wdat   = head_p1.wdat;
    assign o_rd     = head_p1.rd;
    assign o_fflags = head_p1.fflags;

endmodule

// File: tb/tb_e203_exu_fpu_fmis_cvtws_wbck.sv
// Scoreboard bench for the fcvt.w[u].s writeback stage.
module tb_e203_exu_fpu_fmis_cvtws_wbck;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_wdat;
    logic [31:0] i_rs1;
    logic        i_unsgn;
    logic [4:0]  i_rd;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_wdat;
    logic [4:0]  o_rd;
    logic [4:0]  o_fflags;
    logic [4:0]  fflags_acc;
    logic        fflags_clr;

    always #5 clk = ~clk;

    e203_exu_fpu_fmis_cvtws_wbck dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .i_wdat     (i_wdat),
        .i_rs1      (i_rs1),
        .i_unsgn    (i_unsgn),
        .i_rd       (i_rd),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_wdat     (o_wdat),
        .o_rd       (o_rd),
        .o_fflags   (o_fflags),
        .fflags_acc (fflags_acc),
        .fflags_clr (fflags_clr)
    );

    typedef struct {
        string       name;
        logic [31:0] wdat;
        logic [4:0]  rd;
        logic [4:0]  fflags;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest expected entry.
    always @(negedge clk) begin : monitor
        exp_t x;
        if (!rst && o_valid && o_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 32'(o_valid), 32'd0);
            end else begin
                x = sb_q.pop_front();
                check({x.name, ".wdat"}, o_wdat, x.wdat);
                check({x.name, ".fflags"}, 32'(o_fflags), 32'(x.fflags));
                check({x.name, ".rd"}, 32'(o_rd), 32'(x.rd));
            end
        end
    end

    task automatic push_exp(input string name, input logic [31:0] ew, input logic [4:0] rd,
                            input logic [4:0] ef);
        exp_t x;
        x.name   = name;
        x.wdat   = ew;
        x.rd     = rd;
        x.fflags = ef;
        sb_q.push_back(x);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input string name, input logic [31:0] rs1, input logic [31:0] raw,
                        input logic uns, input logic [4:0] rd,
                        input logic [31:0] ew, input logic [4:0] ef);
        bit done;
        done    = 1'b0;
        i_valid = 1'b1;
        i_rs1   = rs1;
        i_wdat  = raw;
        i_unsgn = uns;
        i_rd    = rd;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (i_ready) begin
                push_exp(name, ew, rd, ef);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        check({name, ".accepted"}, 32'(done), 32'd1);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 100 && sb_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x%08h, expected 0x%08h", 32'd1, 32'd0);
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        i_valid    = 1'b0;
        i_wdat     = '0;
        i_rs1      = '0;
        i_unsgn    = 1'b0;
        i_rd       = '0;
        o_ready    = 1'b1;
        fflags_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.o_valid", 32'(o_valid), 32'd0);
        check("rst.i_ready", 32'(i_ready), 32'd1);
        check("rst.o_wdat", o_wdat, 32'd0);
        check("rst.o_rd", 32'(o_rd), 32'd0);
        check("rst.o_fflags", 32'(o_fflags), 32'd0);
        check("rst.fflags_acc", 32'(fflags_acc), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        check("idle.o_valid", 32'(o_valid), 32'd0);
        send("pi_s", 32'h40490FDB, 32'd3, 1'b0, 5'd1, 32'd3, 5'h01);
        check("pi_s.latency", 32'(o_valid), 32'd1);

        send("nan_s",    32'h7FC00000, 32'h12345678, 1'b0, 5'd2,  32'h7FFFFFFF, 5'h10);
        send("nnan_s",   32'hFFC00000, 32'h12345678, 1'b0, 5'd3,  32'h7FFFFFFF, 5'h10);
        send("min_s",    32'hCF000000, 32'h7FFFFFFF, 1'b0, 5'd4,  32'h80000000, 5'h00);
        send("ovfn_s",   32'hCF000001, 32'h80000000, 1'b0, 5'd5,  32'h80000000, 5'h10);
        send("ninf_s",   32'hFF800000, 32'h00000000, 1'b0, 5'd6,  32'h80000000, 5'h10);
        send("big_s",    32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 5'd7,  32'h7FFFFF80, 5'h00);
        send("half_s",   32'h3F000000, 32'h00000000, 1'b0, 5'd8,  32'h00000000, 5'h01);
        send("onep5_s",  32'h3FC00000, 32'h00000001, 1'b0, 5'd9,  32'h00000001, 5'h01);
        send("subn_s",   32'h00000001, 32'h00000000, 1'b0, 5'd10, 32'h00000000, 5'h01);
        send("u2p31_u",  32'h4F000000, 32'h7FFFFFFF, 1'b1, 5'd11, 32'h80000000, 5'h00);
        send("utop_u",   32'h4F7FFFFF, 32'h7FFFFFFF, 1'b1, 5'd12, 32'hFFFFFF00, 5'h00);
        send("nhalf_u",  32'hBF000000, 32'h00000000, 1'b1, 5'd13, 32'h00000000, 5'h01);
        send("none_u",   32'hBF800000, 32'hFFFFFFFF, 1'b1, 5'd14, 32'h00000000, 5'h10);
        send("pinf_u",   32'h7F800000, 32'h7FFFFFFF, 1'b1, 5'd15, 32'hFFFFFFFF, 5'h10);
        send("p2p32_u",  32'h4F800000, 32'h7FFFFFFF, 1'b1, 5'd16, 32'hFFFFFFFF, 5'h10);
        send("nzero_u",  32'h80000000, 32'h00000000, 1'b1, 5'd17, 32'h00000000, 5'h00);
        send("phalf_u",  32'h3F000000, 32'h00000000, 1'b1, 5'd18, 32'h00000000, 5'h01);
        wait_drain();

        fflags_clr = 1'b1;
        @(posedge clk);
        #1;
        fflags_clr = 1'b0;
        check("acc.cleared", 32'(fflags_acc), 32'd0);
        send("acc_nx", 32'h40490FDB, 32'd3, 1'b0, 5'd20, 32'd3, 5'h01);
        send("acc_nv", 32'h7FC00000, 32'd0, 1'b0, 5'd21, 32'h7FFFFFFF, 5'h10);
        wait_drain();
        check("acc.nx_nv", 32'(fflags_acc), 32'h11);
        send("acc_clr_nx", 32'h40490FDB, 32'd3, 1'b0, 5'd22, 32'd3, 5'h01);
        fflags_clr = 1'b1;
        @(posedge clk);
        #1;
        fflags_clr = 1'b0;
        check("acc.clr_with_retire", 32'(fflags_acc), 32'h01);
        wait_drain();

        // Backpressure: three back-to-back offers with the writeback stalled.
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_rs1 = 32'h40000000; i_wdat = 32'd2; i_unsgn = 1'b0; i_rd = 5'd10;
        @(negedge clk);
        check("bp.rdy_empty", 32'(i_ready), 32'd1);
        push_exp("bp_a", 32'd2, 5'd10, 5'h00);
        @(posedge clk);
        #1;
        i_rs1 = 32'h40400000; i_wdat = 32'd3; i_rd = 5'd11;
        check("bp.rdy_head", 32'(i_ready), 32'd1);
        @(negedge clk);
        push_exp("bp_b", 32'd3, 5'd11, 5'h00);
        @(posedge clk);
        #1;
        check("bp.rdy_full", 32'(i_ready), 32'd0);
        i_rs1 = 32'h40800000; i_wdat = 32'd4; i_rd = 5'd12;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("bp.rdy_hold", 32'(i_ready), 32'd0);
            check("bp.head_stable", o_wdat, 32'd2);
        end
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp.rdy_back", 32'(i_ready), 32'd1);
        @(negedge clk);
        push_exp("bp_c", 32'd4, 5'd12, 5'h00);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        wait_drain();

        // Reset while both entries hold results.
        o_ready = 1'b0;
        send("rst_d", 32'h40000000, 32'd2, 1'b0, 5'd20, 32'd2, 5'h00);
        send("rst_e", 32'h40400000, 32'd3, 1'b0, 5'd21, 32'd3, 5'h00);
        check("rst_mid.full", 32'(i_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid.o_valid", 32'(o_valid), 32'd0);
        check("rst_mid.i_ready", 32'(i_ready), 32'd1);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        o_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("post_rst.idle", 32'(o_valid), 32'd0);
        end
        send("post_rst", 32'h40490FDB, 32'd3, 1'b0, 5'd23, 32'd3, 5'h01);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
